instr_byte_queue: RTL and testbench

Circular byte buffer between the instruction fetch unit and the prefix/opcode decode stage. It accepts 16-byte fetch packets, which may start at a nonzero offset after a branch target, and stores them in order. It presents a 16-byte window aligned to the start of the current instruction. The least-significant 32 bits of the window are the 4-byte prefix-scan input of the prefix decoder. The decoder reports the decoded instruction length, and the queue retires that many bytes from the head.

---
 rtl/instr_byte_queue_if.sv | 25 ++
 rtl/instr_byte_queue.sv | 72 +++++++
 tb/tb_instr_byte_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/instr_byte_queue_if.sv
// instr_byte_queue_if: fetch-packet input, decode window and consume handshake of the instruction byte queue
interface instr_byte_queue_if #(
    parameter int IN_BYTES  = 16,
    parameter int WIN_BYTES = 16
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [8*IN_BYTES-1:0]  in_bytes;
    logic [3:0]             in_start;
    logic [8*WIN_BYTES-1:0] win_bytes;
    logic [5:0]             win_count;
    logic                   win_valid;
    logic                   consume_en;
    logic [4:0]             consume_len;
    logic                   consume_err;
    modport master (
        output flush, in_valid, in_bytes, in_start, consume_en, consume_len,
        input  in_ready, win_bytes, win_count, win_valid, consume_err
    );
    modport slave (
        input  flush, in_valid, in_bytes, in_start, consume_en, consume_len,
        output in_ready, win_bytes, win_count, win_valid, consume_err
    );
endinterface

// File: rtl/instr_byte_queue.sv
// instr_byte_queue: circular fetch-byte buffer presenting an instruction-aligned decode window.
// Optional INSTR_BYTE_QUEUE_BYPASS_EN: an empty queue forwards the incoming packet to the window in the same cycle.
module instr_byte_queue #(
    parameter int DEPTH     = 48,
    parameter int IN_BYTES  = 16,
    parameter int WIN_BYTES = 16
) (
    input logic               clk,
    input logic               rst,
    instr_byte_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PB = IN_BYTES > WIN_BYTES ? IN_BYTES : WIN_BYTES;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            err;
    logic [8*PB-1:0] pkt;
    logic [5:0]      n, st_cnt;
    logic            wr, legal, byp;
    function automatic logic [PW-1:0] wrap(input int s);
        return PW'(s >= DEPTH ? s - DEPTH : s);
    endfunction
    assign pkt    = (8*PB)'(bus.in_bytes) >> {bus.in_start, 3'b000};
    assign n      = 6'(IN_BYTES) - 6'(bus.in_start);
    assign st_cnt = int'(count) >= WIN_BYTES ? 6'(WIN_BYTES) : 6'(count);
    assign bus.in_ready    = int'(count) <= DEPTH - IN_BYTES;
    assign wr              = bus.in_valid && bus.in_ready && !bus.flush;
    assign legal           = bus.consume_en && bus.consume_len != '0 && 6'(bus.consume_len) <= bus.win_count;
    assign bus.win_valid   = bus.win_count != '0;
    assign bus.consume_err = err;
`ifdef INSTR_BYTE_QUEUE_BYPASS_EN
    assign byp = count == '0 && wr;
`else
    assign byp = 1'b0;
`endif
    // head window: bypassed packet bytes or storage from rd_ptr, zero above win_count
    always_comb begin
        bus.win_count = byp ? n : st_cnt;
        bus.win_bytes = '0;
        for (int k = 0; k < WIN_BYTES; k++)
            if (6'(k) < bus.win_count)
                bus.win_bytes[8*k +: 8] = byp ? pkt[8*k +: 8] : mem[wrap(int'(rd_ptr) + k)];
    end
    // storage: accepted packet bytes land at wr_ptr onward, wrapping at DEPTH
    always_ff @(posedge clk)
        for (int k = 0; k < IN_BYTES; k++)
            if (wr && 6'(k) < n)
                mem[wrap(int'(wr_ptr) + k)] <= pkt[8*k +: 8];
    // pointers, occupancy and sticky error; flush overrides write and consume
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wrap(int'(wr_ptr) + int'(n));
            if (legal)
                rd_ptr <= wrap(int'(rd_ptr) + int'(bus.consume_len));
            if (bus.consume_en && !legal)
                err <= 1'b1;
            count <= CW'(int'(count) + (wr ? int'(n) : 0) - (legal ? int'(bus.consume_len) : 0));
        end
endmodule

// File: tb/tb_instr_byte_queue.sv
// tb_instr_byte_queue: directed checks of fill/full, wrap, simultaneous write+consume, errors, flush, bypass and async reset
module tb_instr_byte_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    instr_byte_queue_if #(.IN_BYTES(16), .WIN_BYTES(16)) bus ();
    instr_byte_queue #(.DEPTH(48), .IN_BYTES(16), .WIN_BYTES(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [127:0] mkpkt(input logic [7:0] base);
        logic [127:0] p;
        for (int k = 0; k < 16; k++)
            p[8*k +: 8] = base + 8'(k);
        return p;
    endfunction
    task automatic idle();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bytes = '0;
        bus.in_start = '0;
        bus.consume_en = 1'b0;
        bus.consume_len = '0;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask
    task automatic push(input logic [7:0] base, input logic [3:0] st);
        bus.in_valid = 1'b1;
        bus.in_bytes = mkpkt(base);
        bus.in_start = st;
    endtask
    task automatic consume(input logic [4:0] len);
        bus.consume_en = 1'b1;
        bus.consume_len = len;
    endtask
    initial begin
        idle();
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_win_valid", bus.win_valid, 0);
        check("rst_win_count", bus.win_count, 0);
        check("rst_win_bytes", bus.win_bytes, 0);
        check("rst_err", bus.consume_err, 0);
        #11 rst = 1'b0;
        cyc();
        push(8'h00, 0); cyc();
        check("p1_win_count", bus.win_count, 16);
        check("p1_byte0", bus.win_bytes[7:0], 8'h00);
        check("p1_window", bus.win_bytes, mkpkt(8'h00));
        check("p1_in_ready", bus.in_ready, 1);
        push(8'h10, 0); cyc();
        check("c32_count", dut.count, 32);
        check("c32_in_ready", bus.in_ready, 1);
        push(8'h20, 0); cyc();
        check("full_count", dut.count, 48);
        check("full_in_ready", bus.in_ready, 0);
        check("full_wr_wrap", dut.wr_ptr, 0);
        push(8'h30, 0); cyc();
        check("held_count", dut.count, 48);
        consume(16); cyc();
        check("drain_in_ready", bus.in_ready, 1);
        check("drain_byte0", bus.win_bytes[7:0], 8'h10);
        check("drain_count", dut.count, 32);
        bus.flush = 1'b1; push(8'h30, 0); cyc();
        check("flush_drop_count", dut.count, 0);
        check("flush_win_valid", bus.win_valid, 0);
        check("flush_wr_ptr", dut.wr_ptr, 0);
        push(8'h80, 0); cyc(); consume(16); cyc();
        push(8'h90, 0); cyc(); consume(16); cyc();
        push(8'hA0, 8); cyc(); consume(8); cyc();
        check("pre_wrap_rd", dut.rd_ptr, 40);
        check("pre_wrap_wr", dut.wr_ptr, 40);
        check("pre_wrap_count", dut.count, 0);
        push(8'h40, 0); cyc();
        check("wrap_wr_ptr", dut.wr_ptr, 8);
        check("wrap_byte7", bus.win_bytes[63:56], 8'h47);
        check("wrap_window", bus.win_bytes, mkpkt(8'h40));
        consume(6); cyc();
        check("c6_count", dut.count, 10);
        check("c6_byte0", bus.win_bytes[7:0], 8'h46);
        push(8'h50, 4); consume(3); cyc();
        check("sim_count", dut.count, 19);
        check("sim_rd_ptr", dut.rd_ptr, 1);
        check("sim_wr_ptr", dut.wr_ptr, 20);
        check("sim_byte0", bus.win_bytes[7:0], 8'h49);
        check("sim_byte7", bus.win_bytes[63:56], 8'h54);
        bus.flush = 1'b1; cyc();
        push(8'h60, 11); cyc();
        check("short_win_count", bus.win_count, 5);
        check("short_byte0", bus.win_bytes[7:0], 8'h6B);
        check("short_upper_zero", bus.win_bytes[127:40], 0);
        consume(5); cyc();
        check("exact_count", dut.count, 0);
        check("exact_win_valid", bus.win_valid, 0);
        check("exact_err", bus.consume_err, 0);
        push(8'h60, 11); cyc();
        consume(6); cyc();
        check("ill_err", bus.consume_err, 1);
        check("ill_rd_ptr", dut.rd_ptr, 5);
        check("ill_count", dut.count, 5);
        cyc();
        check("ill_err_sticky", bus.consume_err, 1);
        bus.flush = 1'b1; cyc();
        check("flush_err", bus.consume_err, 0);
        check("flush_win_valid2", bus.win_valid, 0);
        consume(1); cyc();
        check("empty_consume_err", bus.consume_err, 1);
        bus.flush = 1'b1; cyc();
        push(8'h60, 0); cyc();
        consume(0); cyc();
        check("zero_len_err", bus.consume_err, 1);
        check("zero_len_count", dut.count, 16);
        bus.flush = 1'b1; cyc();
        push(8'h70, 2); consume(5);
        #1;
`ifdef INSTR_BYTE_QUEUE_BYPASS_EN
        check("byp_win_count", bus.win_count, 14);
        check("byp_byte0", bus.win_bytes[7:0], 8'h72);
        cyc();
        check("byp_count", dut.count, 9);
        check("byp_next_byte0", bus.win_bytes[7:0], 8'h77);
        check("byp_err", bus.consume_err, 0);
`else
        check("nobyp_win_count", bus.win_count, 0);
        cyc();
        check("nobyp_count", dut.count, 14);
        check("nobyp_next_byte0", bus.win_bytes[7:0], 8'h72);
        check("nobyp_err", bus.consume_err, 1);
`endif
        push(8'h00, 0); cyc();
        rst = 1'b1;
        #1;
        check("arst_win_count", bus.win_count, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_count", dut.count, 0);
        check("arst_err", bus.consume_err, 0);
        rst = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
